// File: rtl/io_port_bank.sv
// io_port_bank: decodes Z80-style I/O bus cycles into N_PORTS GP byte ports and a console TX FIFO.
// Ports: clk/reset, address/data_in/data_out/data_oe, nCS/nWE/nOE, port_out/port_in, tx_*, bus_err.
module io_port_bank #(
  parameter int          N_PORTS      = 4,
  parameter logic [15:0] PORT_BASE    = 16'h0010,
  parameter logic [15:0] CONSOLE_ADDR = 16'd2222,
  parameter logic [15:0] STATUS_ADDR  = 16'd2223,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            address,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   data_oe,
  input  logic                   nCS,
  input  logic                   nWE,
  input  logic                   nOE,
  output logic [8*N_PORTS-1:0]   port_out,
  input  logic [8*N_PORTS-1:0]   port_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   bus_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic          wr_prev;
  logic          rd_prev;
  logic          wr_act;
  logic          rd_act;
  logic          wr_ev;
  logic          rd_ev;
  logic          conflict;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic [31:0]   cnt_w;
  logic [4:0]    cnt_sat;
  logic [7:0]    rd_data;

  assign wr_act   = !nCS && !nWE && nOE;
  assign rd_act   = !nCS && !nOE && nWE;
  assign conflict = !nCS && !nWE && !nOE;
  // Edge detect: a strobe held for many clocks acts once.
  assign wr_ev    = wr_act && !wr_prev;
  assign rd_ev    = rd_act && !rd_prev;

  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign tx_valid = !empty;

  assign push_req = wr_ev && (address == CONSOLE_ADDR);
  assign pop      = tx_valid && tx_ready;
  // A pop in the same clock frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev  <= 1'b1;
      rd_prev  <= 1'b1;
      port_out <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      wr_prev <= wr_act;
      rd_prev <= rd_act;
      if (conflict)
        bus_err <= 1'b1;
      if (wr_ev) begin
        for (int k = 0; k < N_PORTS; k++)
          if (address == PORT_BASE + 16'(k))
            port_out[8*k +: 8] <= data_in;
      end
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      // Registered head: next head is the new char when the FIFO
      // is (or becomes) empty, else the entry behind the popped one.
      if (push && (empty || (pop && count == CW'(1))))
        tx_data <= data_in;
      else if (pop && count == CW'(1))
        tx_data <= 8'h00;
      else if (pop)
        tx_data <= mem[rptr + AW'(1)];
      if (drop)
        overflow <= 1'b1;
      else if (rd_ev && address == STATUS_ADDR)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wptr] <= data_in;
  end

  assign cnt_w   = 32'(count);
  assign cnt_sat = (cnt_w > 32'd31) ? 5'd31 : cnt_w[4:0];

  always_comb begin
    rd_data = 8'hFF;
    if (address == CONSOLE_ADDR)
      rd_data = 8'h00;
    else if (address == STATUS_ADDR)
      rd_data = {overflow, full, empty, cnt_sat};
    for (int k = 0; k < N_PORTS; k++)
      if (address == PORT_BASE + 16'(k))
        rd_data = port_in[8*k +: 8];
  end

  assign data_out = rd_data;
  assign data_oe  = !nCS && !nOE;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed vector table plus hand sequences for io_port_bank.
// Drives on falling edges, samples after falling edges.
module tb_io_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        nCS;
  logic        nWE;
  logic        nOE;
  logic [31:0] port_out;
  logic [31:0] port_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  int passed = 0;
  int total  = 0;

  io_port_bank dut (
    .clk(clk), .reset(reset), .address(address),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .nCS(nCS), .nWE(nWE), .nOE(nOE),
    .port_out(port_out), .port_in(port_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_rd;
    logic [31:0] exp_po;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    nCS = 1'b1; nWE = 1'b1; nOE = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                           input int hold);
    address = a; data_in = d;
    nCS = 1'b0; nWE = 1'b0; nOE = 1'b1;
    repeat (hold) @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    address = a;
    nCS = 1'b0; nOE = 1'b0; nWE = 1'b1;
    #1;
    d = data_out;
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  logic [7:0] rd;
  logic [7:0] exp_q [16];

  initial begin
    reset = 1'b1; address = 16'h0; data_in = 8'h0;
    port_in = 32'hDDCCBBAA; tx_ready = 1'b0;
    idle();

    vecs[0]  = '{1'b1, 16'h0010, 8'h11, 8'h00, 32'h00000011};
    vecs[1]  = '{1'b1, 16'h0012, 8'h5A, 8'h00, 32'h005A0011};
    vecs[2]  = '{1'b1, 16'h0014, 8'h77, 8'h00, 32'h005A0011};
    vecs[3]  = '{1'b1, 16'h000F, 8'h66, 8'h00, 32'h005A0011};
    vecs[4]  = '{1'b1, 16'h0013, 8'hC3, 8'h00, 32'hC35A0011};
    vecs[5]  = '{1'b0, 16'h0010, 8'h00, 8'hAA, 32'hC35A0011};
    vecs[6]  = '{1'b0, 16'h0011, 8'h00, 8'hBB, 32'hC35A0011};
    vecs[7]  = '{1'b0, 16'h0013, 8'h00, 8'hDD, 32'hC35A0011};
    vecs[8]  = '{1'b0, 16'h0F00, 8'h00, 8'hFF, 32'hC35A0011};
    vecs[9]  = '{1'b0, 16'd2222, 8'h00, 8'h00, 32'hC35A0011};
    vecs[10] = '{1'b0, 16'd2223, 8'h00, 8'h20, 32'hC35A0011};
    vecs[11] = '{1'b0, 16'h0014, 8'h00, 8'hFF, 32'hC35A0011};

    // Reset state
    do_reset();
    check("reset_port_out", port_out, 32'h0);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h0);
    check("reset_bus_err", {31'b0, bus_err}, 32'h0);

    // Decode table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].din, 1);
      end else begin
        address = vecs[i].addr;
        nCS = 1'b0; nOE = 1'b0; nWE = 1'b1;
        #1;
        check($sformatf("vec%0d_oe", i), {31'b0, data_oe}, 32'h1);
        rd = data_out;
        @(negedge clk);
        idle();
        @(negedge clk);
        check($sformatf("vec%0d_rd", i), {24'b0, rd}, {24'b0, vecs[i].exp_rd});
      end
      check($sformatf("vec%0d_port_out", i), port_out, vecs[i].exp_po);
    end
    check("tbl_fifo_untouched", {31'b0, tx_valid}, 32'h0);

    // 1: held OUT to console acts once, latency 1
    do_reset();
    address = 16'd2222; data_in = 8'h41;
    nCS = 1'b0; nWE = 1'b0; nOE = 1'b1;
    @(negedge clk);
    check("t1_latency_valid", {31'b0, tx_valid}, 32'h1);
    check("t1_latency_data", {24'b0, tx_data}, 32'h41);
    @(negedge clk);
    @(negedge clk);
    idle();
    @(negedge clk);
    bus_read(16'd2223, rd);
    check("t1_status_one", {24'b0, rd}, 32'h01);
    check("t1_tx_data", {24'b0, tx_data}, 32'h41);

    // 2: overflow on 17th write, cleared by status read
    do_reset();
    for (int i = 1; i <= 17; i++) bus_write(16'd2222, 8'(i), 1);
    bus_read(16'd2223, rd);
    check("t2_status_ovf", {24'b0, rd}, 32'hD0);
    bus_read(16'd2223, rd);
    check("t2_status_clr", {24'b0, rd}, 32'h50);

    // 3: push + pop on a full FIFO
    check("t3_head", {24'b0, tx_data}, 32'h01);
    address = 16'd2222; data_in = 8'h99;
    nCS = 1'b0; nWE = 1'b0; nOE = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    idle();
    @(negedge clk);
    bus_read(16'd2223, rd);
    check("t3_status_full", {24'b0, rd}, 32'h50);
    for (int i = 0; i < 15; i++) exp_q[i] = 8'(i + 2);
    exp_q[15] = 8'h99;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_drain%0d", i), {23'b0, tx_valid, tx_data},
            {23'b0, 1'b1, exp_q[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("t3_empty", {31'b0, tx_valid}, 32'h0);
    bus_read(16'd2223, rd);
    check("t3_status_empty", {24'b0, rd}, 32'h20);

    // 5: bus conflict, then strobe held across reset release
    do_reset();
    bus_write(16'h0010, 8'h33, 1);
    address = 16'h0010; data_in = 8'hEE;
    nCS = 1'b0; nWE = 1'b0; nOE = 1'b0;
    @(negedge clk);
    idle();
    @(negedge clk);
    check("t5_bus_err", {31'b0, bus_err}, 32'h1);
    check("t5_port_kept", port_out, 32'h00000033);
    check("t5_fifo_kept", {31'b0, tx_valid}, 32'h0);
    address = 16'h0011; data_in = 8'h44;
    nCS = 1'b0; nWE = 1'b0; nOE = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("t5_err_cleared", {31'b0, bus_err}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("t5_no_write", port_out, 32'h0);

    // 6: reset flushes a partly filled FIFO
    for (int i = 0; i < 5; i++) bus_write(16'd2222, 8'(8'hA0 + i), 1);
    bus_read(16'd2223, rd);
    check("t6_status_five", {24'b0, rd}, 32'h05);
    do_reset();
    check("t6_flushed", {23'b0, tx_valid, tx_data}, 32'h0);
    bus_read(16'd2223, rd);
    check("t6_status_after", {24'b0, rd}, 32'h20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
